sdram_port_mux: RTL and testbench

- Sits directly downstream of the USB transfer engine.
- Arbitrates its word-stream memory port and the GBA cartridge-side request port onto the single SDRAM controller request port.
- GBA has priority, because it is the real-time bus. A starvation guard limits how long USB can be held off.
- USB reads go through a one-word address-tagged buffer, so `usb_rd_valid` can be answered in the same cycle against the current `usb_addr`.

---
 rtl/sdram_port_mux_pkg.sv | 27 ++
 rtl/sdram_port_mux.sv | 193 +++++++++++++++++++
 tb/tb_sdram_port_mux.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_mux_pkg.sv
// Shared types for the SDRAM port mux: FSM states, request owner and the
// latched request that is presented to the SDRAM controller.
package sdram_port_mux_pkg;

  // Widest word address a 32-bit byte address can carry.
  localparam int WADDR_MAX_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_GBA = 1'b0,
    OWN_USB = 1'b1
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [WADDR_MAX_W-1:0] waddr;
    logic [31:0]            wdata;
    logic [3:0]             be;
  } mem_req_t;

endpackage

// File: rtl/sdram_port_mux.sv
// Arbitrates the USB word-stream port and the GBA cartridge port onto one
// SDRAM controller request port. GBA has priority; a starvation counter
// forces a USB grant after STARVE_LIMIT consecutive GBA grants. USB reads
// land in a one-word address-tagged buffer so usb_rd can be answered
// combinationally against the current usb_addr.
module sdram_port_mux
  import sdram_port_mux_pkg::*;
#(
  parameter int ADDR_W       = 23,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  // USB side
  input  logic [31:0]       usb_addr,
  input  logic              usb_wr,
  input  logic [31:0]       usb_wr_data,
  output logic              usb_wr_ready,
  input  logic              usb_rd,
  output logic              usb_rd_valid,
  output logic [31:0]       usb_rd_data,
  // GBA side
  input  logic              gba_req,
  input  logic              gba_we,
  input  logic [31:0]       gba_addr,
  input  logic [31:0]       gba_wdata,
  input  logic [3:0]        gba_be,
  output logic              gba_ack,
  output logic [31:0]       gba_rdata,
  // SDRAM controller side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  mem_req_t            req_q, req_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [31:0]         buf_data_q, buf_data_d;
  logic [31:0]         gba_rdata_q, gba_rdata_d;

  logic [ADDR_W-1:0]   usb_waddr_s;
  logic [ADDR_W-1:0]   gba_waddr_s;
  logic                buf_hit_s;
  logic                usb_pend_s;
  logic                guard_s;
  logic                gba_win_s;
  logic                usb_win_s;

  // Word addresses; bits above ADDR_W+1 are dropped so the space wraps.
  assign usb_waddr_s = usb_addr[ADDR_W+1:2];
  assign gba_waddr_s = gba_addr[ADDR_W+1:2];

  assign buf_hit_s  = buf_valid_q && (buf_addr_q == usb_waddr_s);
  // A usb_rd that already hits the buffer needs no memory access.
  assign usb_pend_s = usb_wr || (usb_rd && !buf_hit_s);
  assign guard_s    = usb_pend_s && (starve_q == STARVE_MAX);
  assign gba_win_s  = gba_req && !guard_s;
  assign usb_win_s  = usb_pend_s && !gba_win_s;

  // Next-state logic for the arbiter FSM, request registers and starve counter.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_d       = req_q;
    starve_d    = starve_q;
    gba_rdata_d = gba_rdata_q;
    case (state_q)
      IDLE: begin
        if (gba_win_s) begin
          req_d.we    = gba_we;
          req_d.waddr = WADDR_MAX_W'(gba_waddr_s);
          req_d.wdata = gba_wdata;
          req_d.be    = gba_be;
          owner_d     = OWN_GBA;
          state_d     = ISSUE;
        end else if (usb_win_s) begin
          // usb_wr wins over a simultaneous (illegal) usb_rd.
          req_d.we    = usb_wr;
          req_d.waddr = WADDR_MAX_W'(usb_waddr_s);
          req_d.wdata = usb_wr_data;
          req_d.be    = 4'hF;
          owner_d     = OWN_USB;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
        if (!usb_pend_s || usb_win_s) begin
          starve_d = '0;
        end else if (gba_win_s && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + CNT_W'(1);
        end else begin
          starve_d = starve_q;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (req_q.we) begin
            state_d = (owner_q == OWN_USB) ? IDLE : RESP;
          end else begin
            state_d = WAIT_RD;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_GBA) begin
            gba_rdata_d = mem_rdata;
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_RD;
        end
      end
      RESP: begin
        // One ack cycle, so a still-held gba_req is not re-granted.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next-state logic for the one-word USB read buffer.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if ((state_q == WAIT_RD) && mem_rvalid && (owner_q == OWN_USB)) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = req_q.waddr[ADDR_W-1:0];
      buf_data_d  = mem_rdata;
    end else if (buf_valid_q && !buf_hit_s) begin
      // Address moved on: the held word belongs to an abandoned transfer.
      buf_valid_d = 1'b0;
    end else if (usb_rd && buf_hit_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_GBA;
      req_q       <= '0;
      starve_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 32'd0;
      gba_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      starve_q    <= starve_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      gba_rdata_q <= gba_rdata_d;
    end
  end

  assign mem_req      = (state_q == ISSUE);
  assign mem_we       = req_q.we;
  assign mem_addr     = req_q.waddr[ADDR_W-1:0];
  assign mem_wdata    = req_q.wdata;
  assign mem_be       = req_q.be;
  assign gba_ack      = (state_q == RESP);
  assign gba_rdata    = gba_rdata_q;
  assign usb_wr_ready = (state_q == ISSUE) && (owner_q == OWN_USB) && req_q.we && mem_ready;
  assign usb_rd_valid = usb_rd && buf_hit_s;
  assign usb_rd_data  = buf_data_q;

endmodule

// File: tb/tb_sdram_port_mux.sv
// Directed bench for sdram_port_mux with a small SDRAM controller model
// (immediate mem_ready, configurable read latency).
module tb_sdram_port_mux;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       usb_addr;
  logic              usb_wr;
  logic [31:0]       usb_wr_data;
  logic              usb_wr_ready;
  logic              usb_rd;
  logic              usb_rd_valid;
  logic [31:0]       usb_rd_data;
  logic              gba_req;
  logic              gba_we;
  logic [31:0]       gba_addr;
  logic [31:0]       gba_wdata;
  logic [3:0]        gba_be;
  logic              gba_ack;
  logic [31:0]       gba_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  // Controller model state
  logic              ready_en = 1'b1;
  int                lat = 2;
  int                rd_cnt = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  int                n_reads = 0;
  logic [ADDR_W-1:0] wr_log_addr[$];
  logic [31:0]       wr_log_data[$];

  always #5 clk = ~clk;

  sdram_port_mux #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .usb_addr(usb_addr), .usb_wr(usb_wr), .usb_wr_data(usb_wr_data),
    .usb_wr_ready(usb_wr_ready), .usb_rd(usb_rd), .usb_rd_valid(usb_rd_valid),
    .usb_rd_data(usb_rd_data),
    .gba_req(gba_req), .gba_we(gba_we), .gba_addr(gba_addr), .gba_wdata(gba_wdata),
    .gba_be(gba_be), .gba_ack(gba_ack), .gba_rdata(gba_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  assign mem_ready = mem_req & ready_en;

  function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
    return {9'h1A5, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_mem"}, 64'({mem_req, mem_we, mem_be, mem_addr}), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_gba"}, 64'({gba_ack, gba_rdata}), 64'd0);
    check({tag, "_usb"}, 64'({usb_wr_ready, usb_rd_valid, usb_rd_data}), 64'd0);
  endtask

  // Controller model: decides at each falling edge what the next rising edge sees.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pat(rd_addr);
      end
    end
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        wr_log_addr.push_back(mem_addr);
        wr_log_data.push_back(mem_wdata);
      end else begin
        rd_cnt  = lat;
        rd_addr = mem_addr;
        n_reads++;
      end
    end
  end

  initial begin
    int k, first_rdy, n_rdy, acks, rdy_c;
    int vcyc[4];
    logic got, usb_got, usb_done, stop;

    rst = 1'b1; usb_addr = 32'd0; usb_wr = 1'b0; usb_wr_data = 32'd0; usb_rd = 1'b0;
    gba_req = 1'b0; gba_we = 1'b0; gba_addr = 32'd0; gba_wdata = 32'd0; gba_be = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: USB write of 0x8C8D8E8F at byte 0x10
    wr_log_addr.delete(); wr_log_data.delete();
    first_rdy = -1; n_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      usb_addr = 32'h10; usb_wr_data = 32'h8C8D8E8F; usb_wr = (n_rdy == 0);
      #1;
      if (usb_wr_ready) begin
        n_rdy++;
        if (first_rdy < 0) first_rdy = c;
        check("t1_addr", 64'(mem_addr), 64'h4);
        check("t1_be", 64'(mem_be), 64'hF);
        check("t1_we", 64'(mem_we), 64'd1);
      end
    end
    usb_wr = 1'b0;
    check("t1_rdy_cycle", 64'(first_rdy), 64'd1);
    check("t1_rdy_pulses", 64'(n_rdy), 64'd1);
    check("t1_nwr", 64'(wr_log_addr.size()), 64'd1);
    if (wr_log_addr.size() > 0) check("t1_wr", 64'({wr_log_addr[0], wr_log_data[0]}), {9'd0, 23'h4, 32'h8C8D8E8F});

    // 2: USB read stream of 4 words, latency 2, usb_rd dropped cycles 14..16
    lat = 2; n_reads = 0; k = 0;
    for (int i = 0; i < 4; i++) vcyc[i] = -1;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      usb_rd = (k < 4) && !(c >= 14 && c <= 16);
      usb_addr = 32'(k * 4);
      #1;
      if (c >= 14 && c <= 16) check("t2_hold_novalid", 64'(usb_rd_valid), 64'd0);
      if (usb_rd_valid) begin
        check("t2_data", 64'(usb_rd_data), 64'(pat(ADDR_W'(k))));
        if (k < 4) vcyc[k] = c;
        k++;
      end
    end
    usb_rd = 1'b0;
    check("t2_words", 64'(k), 64'd4);
    check("t2_reads", 64'(n_reads), 64'd4);
    check("t2_cyc0", 64'(vcyc[0]), 64'd4);
    check("t2_cyc1", 64'(vcyc[1]), 64'd9);
    check("t2_cyc2_held", 64'(vcyc[2]), 64'd17);
    check("t2_cyc3", 64'(vcyc[3]), 64'd22);

    // 3: GBA read at 0x100 arriving while a USB read (byte 0x40) is in WAIT_RD
    lat = 3; acks = 0; usb_got = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      usb_addr = 32'h40; usb_rd = !usb_got;
      gba_req = (c >= 2) && (acks == 0); gba_we = 1'b0; gba_addr = 32'h100; gba_be = 4'hF;
      #1;
      if (usb_rd_valid) begin
        check("t3_usb_data", 64'(usb_rd_data), 64'(pat(23'h10)));
        check("t3_usb_cyc", 64'(c), 64'd5);
        usb_got = 1'b1;
      end
      if (c >= 2 && c <= 5) check("t3_gba_waits", 64'(mem_req), 64'd0);
      if (c == 6) check("t3_gba_issue", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 23'h40}));
      if (gba_ack) begin
        acks++;
        check("t3_ack_cyc", 64'(c), 64'd10);
        check("t3_rdata", 64'(gba_rdata), 64'(pat(23'h40)));
      end
    end
    gba_req = 1'b0; usb_rd = 1'b0;
    check("t3_ack_count", 64'(acks), 64'd1);
    check("t3_usb_got", 64'(usb_got), 64'd1);

    // 4: starvation guard with gba_req held and a USB write pending
    wr_log_addr.delete(); wr_log_data.delete();
    usb_done = 1'b0; stop = 1'b0; rdy_c = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gba_req = !stop; gba_we = 1'b1; gba_addr = 32'h200; gba_wdata = 32'h600DF00D; gba_be = 4'h3;
      usb_wr = !usb_done; usb_addr = 32'h300; usb_wr_data = 32'h55AA0001;
      #1;
      if (usb_wr_ready) begin
        usb_done = 1'b1;
        rdy_c = c;
      end
      if (gba_ack && usb_done) stop = 1'b1;
    end
    gba_req = 1'b0; usb_wr = 1'b0;
    check("t4_usb_rdy_cyc", 64'(rdy_c), 64'd25);
    check("t4_nwr", 64'(wr_log_addr.size()), 64'd10);
    for (int i = 0; i < wr_log_addr.size(); i++) begin
      check("t4_order", 64'(wr_log_addr[i]), (i == 8) ? 64'hC0 : 64'h80);
    end
    if (wr_log_data.size() > 8) check("t4_usb_data", 64'(wr_log_data[8]), 64'h55AA0001);

    // 5: usb_addr jumps to 0x2000 while the buffer holds word 0
    lat = 2; n_reads = 0; got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      usb_addr = (c >= 5) ? 32'h2000 : 32'h0;
      usb_rd = (c == 0) || (c >= 5 && !got);
      #1;
      if (c == 5) check("t5_no_false_valid", 64'(usb_rd_valid), 64'd0);
      if (c == 6) check("t5_issue", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 23'h800}));
      if (usb_rd_valid) begin
        check("t5_data", 64'(usb_rd_data), 64'(pat(23'h800)));
        check("t5_cyc", 64'(c), 64'd9);
        got = 1'b1;
      end
    end
    usb_rd = 1'b0;
    check("t5_got", 64'(got), 64'd1);
    check("t5_reads", 64'(n_reads), 64'd2);

    // 6: reset in WAIT_RD, late mem_rvalid one cycle after release
    lat = 4; got = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      usb_addr = 32'h80;
      rst = (c == 2) || (c == 3);
      usb_rd = (c <= 1) || (c >= 6 && !got);
      #1;
      if (c == 3) check_outs_zero("t6_in_reset");
      if (c == 5) check_outs_zero("t6_late_rvalid");
      if (c == 6) check("t6_no_stale_buf", 64'(usb_rd_valid), 64'd0);
      if (usb_rd_valid) begin
        check("t6_data", 64'(usb_rd_data), 64'(pat(23'h20)));
        check("t6_cyc", 64'(c), 64'd12);
        got = 1'b1;
      end
    end
    usb_rd = 1'b0;
    check("t6_got", 64'(got), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
